// File: rtl/fetch_redirect_unit.sv
// Front-end PC generator / fetch sequencer: issues sequential fetches, buffers responses,
// and turns branch redirects into a flush plus squash. Define FETCH_RAS_EN for the return-address stack.
module fetch_redirect_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          FETCH_BYTES = 4,
   parameter int          FIFO_DEPTH  = 4,
   parameter int          RAS_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        branch_taken,
   input  logic [31:0] branch_pc,
   input  logic        is_jsr,
   input  logic [31:0] link_pc,
   input  logic        ret_taken,
   output logic        req_valid,
   output logic [31:0] req_addr,
   input  logic        req_ready,
   input  logic        rsp_valid,
   input  logic [31:0] rsp_data,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_data,
   input  logic        if_ready,
   output logic        flush,
   output logic        ras_underflow
);
   localparam int          PW      = $clog2(FIFO_DEPTH);
   localparam int          CW      = PW + 1;
   localparam logic [31:0] PC_STEP = 32'(FETCH_BYTES);

   typedef enum logic [1:0] {ST_RESET = 2'd0, ST_RUN = 2'd1, ST_FLUSH = 2'd2} state_t;

   state_t        state_reg, state_next;
   logic          armed_reg;
   logic [31:0]   fetch_pc_reg, resp_pc_reg;
   logic [CW-1:0] outstanding_reg, occupancy_reg, discard_reg, outstanding_next;
   logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [31:0]   fifo_pc_mem   [FIFO_DEPTH];
   logic [31:0]   fifo_data_mem [FIFO_DEPTH];
   logic          active, redirect, req_fire, rsp_keep, if_pop;
   logic [31:0]   target;

   assign active    = (state_reg != ST_RESET);
   // Outstanding requests plus buffered words never exceed the buffer, so a push always has room.
   assign req_valid = (state_reg == ST_RUN) &&
                      (({1'b0, outstanding_reg} + {1'b0, occupancy_reg}) < (CW+1)'(FIFO_DEPTH));
   assign req_addr  = fetch_pc_reg;
   assign req_fire  = req_valid && req_ready;
   assign if_valid  = (occupancy_reg != '0);
   assign if_pc     = fifo_pc_mem[rd_ptr_reg];
   assign if_data   = fifo_data_mem[rd_ptr_reg];
   assign if_pop    = if_valid && if_ready;
   assign flush     = (state_reg == ST_FLUSH);
   assign rsp_keep  = rsp_valid && (discard_reg == '0) && !redirect;
   assign outstanding_next = outstanding_reg + CW'(req_fire) - CW'(rsp_valid);

`ifdef FETCH_RAS_EN
   localparam int RW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int RC = $clog2(RAS_DEPTH + 1);

   logic [31:0]   ras_mem [RAS_DEPTH];
   logic [RW-1:0] ras_top_reg, ras_top_inc, ras_top_dec;
   logic [RC-1:0] ras_cnt_reg;
   logic          ras_push, ras_pop, ras_empty, ras_underflow_reg;

   assign ras_empty   = (ras_cnt_reg == '0);
   // A pop requires !branch_taken, so a push in the same cycle always wins.
   assign ras_push    = active && branch_taken && is_jsr;
   assign ras_pop     = active && ret_taken && !branch_taken;
   assign ras_top_inc = (ras_top_reg == RW'(RAS_DEPTH - 1)) ? '0 : ras_top_reg + 1'b1;
   assign ras_top_dec = (ras_top_reg == '0) ? RW'(RAS_DEPTH - 1) : ras_top_reg - 1'b1;
   assign redirect    = active && (branch_taken || ret_taken);
   assign target      = branch_taken ? branch_pc : (ras_empty ? RESET_PC : ras_mem[ras_top_reg]);
   assign ras_underflow = ras_underflow_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         ras_top_reg       <= '0;
         ras_cnt_reg       <= '0;
         ras_underflow_reg <= 1'b0;
      end else begin
         ras_underflow_reg <= ras_pop && ras_empty;
         if (ras_push) begin
            // Circular stack: a push onto a full stack overwrites the oldest entry.
            ras_top_reg <= ras_top_inc;
            if (ras_cnt_reg != RC'(RAS_DEPTH))
               ras_cnt_reg <= ras_cnt_reg + 1'b1;
         end else if (ras_pop && !ras_empty) begin
            ras_top_reg <= ras_top_dec;
            ras_cnt_reg <= ras_cnt_reg - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && ras_push)
         ras_mem[ras_top_inc] <= link_pc;
   end
`else
   logic unused_ras;
   assign unused_ras    = &{1'b0, ret_taken, is_jsr, link_pc, 1'(RAS_DEPTH)};
   assign redirect      = active && branch_taken;
   assign target        = branch_pc;
   assign ras_underflow = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_RESET;
         armed_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         armed_reg <= 1'b1;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_RESET: if (armed_reg) state_next = ST_RUN;
         ST_RUN:   if (redirect) state_next = ST_FLUSH;
         ST_FLUSH: state_next = redirect ? ST_FLUSH : ST_RUN;
         default:  state_next = ST_RESET;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_reg    <= RESET_PC;
         resp_pc_reg     <= RESET_PC;
         outstanding_reg <= '0;
         occupancy_reg   <= '0;
         discard_reg     <= '0;
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
      end else begin
         outstanding_reg <= outstanding_next;
         if (redirect) begin
            // Everything still in flight after this edge belongs to the old path.
            fetch_pc_reg  <= target;
            resp_pc_reg   <= target;
            occupancy_reg <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            discard_reg   <= outstanding_next;
         end else begin
            if (req_fire)
               fetch_pc_reg <= fetch_pc_reg + PC_STEP;
            if (rsp_valid && (discard_reg != '0))
               discard_reg <= discard_reg - 1'b1;
            if (rsp_keep) begin
               wr_ptr_reg  <= wr_ptr_reg + 1'b1;
               resp_pc_reg <= resp_pc_reg + PC_STEP;
            end
            if (if_pop)
               rd_ptr_reg <= rd_ptr_reg + 1'b1;
            occupancy_reg <= occupancy_reg + CW'(rsp_keep) - CW'(if_pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && rsp_keep) begin
         fifo_pc_mem[wr_ptr_reg]   <= resp_pc_reg;
         fifo_data_mem[wr_ptr_reg] <= rsp_data;
      end
   end
endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: epoch-tagged queue model of requests, buffer and return stack,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_redirect_unit;
   logic        clk = 1'b0;
   logic        rst, branch_taken, is_jsr, ret_taken, req_ready, rsp_valid, if_ready;
   logic [31:0] branch_pc, link_pc, rsp_data;
   logic        req_valid, if_valid, flush, ras_underflow;
   logic [31:0] req_addr, if_pc, if_data;

   always #5 clk = ~clk;

   fetch_redirect_unit dut (
      .clk(clk), .rst(rst), .branch_taken(branch_taken), .branch_pc(branch_pc),
      .is_jsr(is_jsr), .link_pc(link_pc), .ret_taken(ret_taken),
      .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .if_valid(if_valid), .if_pc(if_pc), .if_data(if_data), .if_ready(if_ready),
      .flush(flush), .ras_underflow(ras_underflow)
   );

`ifdef FETCH_RAS_EN
   localparam bit RAS_ON = 1'b1;
`else
   localparam bit RAS_ON = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;
   int rsp_mode = 0;   // 0 silent, 1 respond whenever possible, 2 random
   int d_acc = 0;      // handshakes observed on the DUT

   // Model: each in-flight request remembers the fetch epoch it was issued in.
   typedef struct { logic [31:0] addr; int epoch; } mreq_t;
   mreq_t       mem_q[$];
   logic [31:0] fq_pc[$];
   logic [31:0] fq_data[$];
   logic [31:0] ras_q[$];
   logic [31:0] m_fetch_pc = 32'h0;
   int          m_epoch = 0;
   int          m_since_rst = 0;
   bit          m_flush = 1'b0;
   bit          m_und = 1'b0;

   function automatic bit m_req_valid();
      return (m_since_rst >= 2) && !m_flush && ((mem_q.size() + fq_pc.size()) < 4);
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      bit          acc, pop, redir, und, do_push, do_pop;
      logic [31:0] tgt;
      mreq_t       r;
      if (rsp_mode == 1)
         rsp_valid = (mem_q.size() > 0);
      else if (rsp_mode == 2)
         rsp_valid = (mem_q.size() > 0) && ($urandom_range(0, 2) != 0);
      else
         rsp_valid = 1'b0;
      rsp_data = $urandom;
      if (req_valid && req_ready) d_acc++;
      acc = m_req_valid() && req_ready;
      pop = (fq_pc.size() > 0) && if_ready;
      redir = 1'b0; und = 1'b0; do_push = 1'b0; do_pop = 1'b0; tgt = branch_pc;
      if (m_since_rst >= 2) begin
         if (branch_taken) begin
            redir = 1'b1;
            do_push = RAS_ON && is_jsr;
         end else if (RAS_ON && ret_taken) begin
            redir = 1'b1;
            if (ras_q.size() == 0) begin
               tgt = 32'h0;
               und = 1'b1;
            end else begin
               tgt = ras_q[$];
               do_pop = 1'b1;
            end
         end
      end
      @(posedge clk);
      if (rst) begin
         mem_q.delete(); fq_pc.delete(); fq_data.delete(); ras_q.delete();
         m_fetch_pc = 32'h0; m_since_rst = 0; m_flush = 1'b0; m_und = 1'b0; m_epoch++;
      end else begin
         if (pop) begin
            void'(fq_pc.pop_front());
            void'(fq_data.pop_front());
         end
         if (rsp_valid && mem_q.size() > 0) begin
            r = mem_q.pop_front();
            if (r.epoch == m_epoch && !redir) begin
               fq_pc.push_back(r.addr);
               fq_data.push_back(rsp_data);
            end
         end
         if (acc) begin
            mem_q.push_back('{m_fetch_pc, m_epoch});
            m_fetch_pc = m_fetch_pc + 32'd4;
         end
         if (redir) begin
            m_epoch++;
            fq_pc.delete(); fq_data.delete();
            m_fetch_pc = tgt;
         end
         if (do_push) begin
            ras_q.push_back(link_pc);
            if (ras_q.size() > 4) void'(ras_q.pop_front());
         end
         if (do_pop) void'(ras_q.pop_back());
         m_flush = redir;
         m_und = und;
         if (m_since_rst < 2) m_since_rst++;
      end
      #1;
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         cmp("req_valid", req_valid, 32'(m_req_valid()));
         cmp("req_addr", req_addr, m_fetch_pc);
         cmp("if_valid", if_valid, 32'(fq_pc.size() > 0));
         if (fq_pc.size() > 0) begin
            cmp("if_pc", if_pc, fq_pc[0]);
            cmp("if_data", if_data, fq_data[0]);
         end
         cmp("flush", flush, 32'(m_flush));
         cmp("ras_underflow", ras_underflow, 32'(m_und));
         if (if_valid && if_ready)
            $display("xfer pc=%h data=%h", if_pc, if_data);
      end
   end

   task automatic idle_inputs();
      branch_taken = 1'b0; ret_taken = 1'b0; is_jsr = 1'b0;
      branch_pc = 32'h0; link_pc = 32'h0;
      req_ready = 1'b0; if_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 32'h0;
      rsp_mode = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      cmp_en = 1'b1;
      tick(); tick();
      cmp("rst_req_valid", req_valid, 32'h0);
      cmp("rst_req_addr", req_addr, 32'h0);
      cmp("rst_if_valid", if_valid, 32'h0);
      cmp("rst_flush", flush, 32'h0);
      cmp("rst_ras_underflow", ras_underflow, 32'h0);
      rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] seen[$];

      // Sequential fetch straight out of reset.
      do_reset();
      req_ready = 1'b1; if_ready = 1'b1; rsp_mode = 1;
      tick();
      cmp("t1_hold_after_release", req_valid, 32'h0);
      tick();
      cmp("t1_first_valid", req_valid, 32'h1);
      for (int i = 0; i < 8; i++) begin
         if (i < 4) cmp("t1_req_addr", req_addr, 32'(i * 4));
         tick();
         if (if_valid) seen.push_back(if_pc);
      end
      cmp("t1_if_count", 32'(seen.size() >= 4), 32'h1);
      for (int i = 0; i < 4 && i < seen.size(); i++)
         cmp("t1_if_pc", seen[i], 32'(i * 4));

      // Decode stalled: the buffer cap stops fetching after four requests.
      do_reset();
      req_ready = 1'b1; if_ready = 1'b0; rsp_mode = 1; d_acc = 0;
      repeat (10) tick();
      cmp("t2_accepted", 32'(d_acc), 32'd4);
      cmp("t2_stalled", req_valid, 32'h0);
      cmp("t2_stall_addr", req_addr, 32'h10);
      cmp("t2_head_pc", if_pc, 32'h0);
      if_ready = 1'b1;
      tick();
      cmp("t2_resume_valid", req_valid, 32'h1);
      cmp("t2_resume_addr", req_addr, 32'h10);

      // Redirect with 0x8 and 0xC still outstanding.
      do_reset();
      req_ready = 1'b1; if_ready = 1'b1; rsp_mode = 0;
      repeat (6) tick();
      req_ready = 1'b0; rsp_mode = 1;
      repeat (2) tick();
      rsp_mode = 0; branch_taken = 1'b1; branch_pc = 32'h5000;
      tick();
      branch_taken = 1'b0;
      cmp("t3_flush", flush, 32'h1);
      cmp("t3_no_req_in_flush", req_valid, 32'h0);
      rsp_mode = 1; req_ready = 1'b1;
      tick();
      cmp("t3_flush_cleared", flush, 32'h0);
      cmp("t3_target_valid", req_valid, 32'h1);
      cmp("t3_target_addr", req_addr, 32'h5000);
      for (int k = 0; k < 20 && !if_valid; k++) tick();
      cmp("t3_if_valid", if_valid, 32'h1);
      cmp("t3_first_if_pc", if_pc, 32'h5000);

      // Redirect coinciding with a response and an accepted request.
      do_reset();
      req_ready = 1'b1; if_ready = 1'b1; rsp_mode = 0;
      repeat (3) tick();
      rsp_mode = 1; branch_taken = 1'b1; branch_pc = 32'h800;
      tick();
      branch_taken = 1'b0;
      cmp("t4_flush", flush, 32'h1);
      cmp("t4_no_stale", if_valid, 32'h0);
      for (int k = 0; k < 20 && !if_valid; k++) tick();
      cmp("t4_if_valid", if_valid, 32'h1);
      cmp("t4_first_if_pc", if_pc, 32'h800);

      // Address wrap at the top of the 32-bit space.
      do_reset();
      req_ready = 1'b0; if_ready = 1'b1; rsp_mode = 1;
      repeat (2) tick();
      branch_taken = 1'b1; branch_pc = 32'hFFFF_FFF8;
      tick();
      branch_taken = 1'b0;
      tick();
      req_ready = 1'b1;
      cmp("t5_addr0", req_addr, 32'hFFFF_FFF8);
      tick();
      cmp("t5_addr1", req_addr, 32'hFFFF_FFFC);
      tick();
      cmp("t5_addr2", req_addr, 32'h0000_0000);

      // Return-address stack behaviour.
      do_reset();
      req_ready = 1'b1; if_ready = 1'b1; rsp_mode = 1;
      repeat (2) tick();
      branch_taken = 1'b1; is_jsr = 1'b1; branch_pc = 32'h7000; link_pc = 32'h1234;
      tick();
      branch_taken = 1'b0; is_jsr = 1'b0;
      cmp("t6_jsr_target", req_addr, 32'h7000);
      repeat (2) tick();
      ret_taken = 1'b1;
      tick();
      ret_taken = 1'b0;
`ifdef FETCH_RAS_EN
      cmp("t6_ret_flush", flush, 32'h1);
      cmp("t6_ret_no_underflow", ras_underflow, 32'h0);
      tick();
      cmp("t6_ret_addr", req_addr, 32'h1234);
      ret_taken = 1'b1;
      tick();
      ret_taken = 1'b0;
      cmp("t6_underflow_pulse", ras_underflow, 32'h1);
      cmp("t6_underflow_flush", flush, 32'h1);
      tick();
      cmp("t6_underflow_clear", ras_underflow, 32'h0);
      cmp("t6_underflow_addr", req_addr, 32'h0);
`else
      cmp("t6_ret_ignored_flush", flush, 32'h0);
      cmp("t6_ret_ignored_underflow", ras_underflow, 32'h0);
`endif

      // Randomized traffic including redirects, returns and occasional resets.
      do_reset();
      rsp_mode = 2;
      for (int n = 0; n < 3000; n++) begin
         rst          = ($urandom_range(0, 399) == 0);
         req_ready    = ($urandom_range(0, 3) != 0);
         if_ready     = ($urandom_range(0, 2) != 0);
         branch_taken = ($urandom_range(0, 19) == 0);
         branch_pc    = $urandom;
         is_jsr       = $urandom_range(0, 1);
         link_pc      = $urandom;
         ret_taken    = ($urandom_range(0, 15) == 0);
         tick();
      end
      rst = 1'b0;
      idle_inputs();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
